// File: rtl/cci_mpf_c0_rd_arb_if.sv
// c0 (read-request) channel between the arbiter and the FIU side of cci_mpf_if.
// The master drives read requests and consumes almost-full and read responses.
interface cci_mpf_c0_rd_arb_if #(
    parameter int ADDR_W  = 42,
    parameter int MDATA_W = 16
) ();
    logic               fiu_almfull;
    logic               tx_valid;
    logic [ADDR_W-1:0]  tx_addr;
    logic [MDATA_W-1:0] tx_mdata;
    logic               rx_valid;
    logic [MDATA_W-1:0] rx_mdata;

    modport master (
        input  fiu_almfull,
        input  rx_valid,
        input  rx_mdata,
        output tx_valid,
        output tx_addr,
        output tx_mdata
    );

    modport slave (
        output fiu_almfull,
        output rx_valid,
        output rx_mdata,
        input  tx_valid,
        input  tx_addr,
        input  tx_mdata
    );
endinterface

// File: rtl/cci_mpf_c0_rd_arb.sv
// Round-robin arbiter sharing one c0 read-request channel among N_REQ requesters.
// Requests are tagged with the requester ID in the upper mdata bits; responses are
// routed back by that tag. Per-requester credit counters bound in-flight reads.

// Simulation-time checker for the arbiter: grant shape, credit bound, requester hold rule.
module cci_mpf_c0_rd_arb_chk #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 42,
    parameter int UW      = 14,
    parameter int MAX_OUT = 32,
    parameter int CNT_W   = 6
) (
    input logic                    clk,
    input logic                    reset,
    input logic [N_REQ-1:0]        req_valid,
    input logic [N_REQ*ADDR_W-1:0] req_addr,
    input logic [N_REQ*UW-1:0]     req_mdata,
    input logic [N_REQ-1:0]        req_grant,
    input logic [N_REQ*CNT_W-1:0]  outstanding
);
    a_grant_onehot0: assert property (@(posedge clk) $onehot0(req_grant));

    for (genvar g = 0; g < N_REQ; g++) begin : g_chk
        a_cnt_bound: assert property (@(posedge clk)
            outstanding[g*CNT_W +: CNT_W] <= CNT_W'(MAX_OUT));

        a_req_hold: assert property (@(posedge clk) disable iff (reset == 1'b0)
            (req_valid[g] && !req_grant[g]) |=>
            (req_valid[g] && $stable(req_addr[g*ADDR_W +: ADDR_W])
                          && $stable(req_mdata[g*UW +: UW])));
    end
endmodule

module cci_mpf_c0_rd_arb #(
    parameter  int N_REQ   = 4,
    parameter  int ADDR_W  = 42,
    parameter  int MDATA_W = 16,
    parameter  int MAX_OUT = 32,
    localparam int ID_W    = $clog2(N_REQ),
    localparam int UW      = MDATA_W - ID_W,
    localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*UW-1:0]     req_mdata,
    output logic [N_REQ-1:0]        req_grant,
    cci_mpf_c0_rd_arb_if.master     c0,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [UW-1:0]           rsp_mdata,
    output logic [N_REQ*CNT_W-1:0]  outstanding,
    output logic                    err_rsp
);
    // One-hot decode of a requester ID.
    function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    logic [ID_W-1:0]    ptr_r;
    logic [CNT_W-1:0]   cnt_r [N_REQ];
    logic               tx_valid_r;
    logic [ADDR_W-1:0]  tx_addr_r;
    logic [MDATA_W-1:0] tx_mdata_r;
    logic [N_REQ-1:0]   rsp_valid_r;
    logic [UW-1:0]      rsp_mdata_r;
    logic               err_r;

    logic [N_REQ-1:0]   eligible_s;
    logic [N_REQ-1:0]   grant_s;
    logic               grant_any_s;
    logic [ID_W-1:0]    grant_id_s;
    logic [ID_W-1:0]    ptr_nxt_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [UW-1:0]      sel_mdata_s;
    logic [ID_W-1:0]    rx_id_s;
    logic [N_REQ-1:0]   rx_dec_s;
    logic               rx_ok_s;
    logic               rx_bad_s;
    logic               zero_hit_s;
    logic [CNT_W-1:0]   cnt_nxt_s [N_REQ];

    // A requester may compete only while it holds a request and has a free credit.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible_s[i] = req_valid[i] && (cnt_r[i] < CNT_W'(MAX_OUT));
        end
    end

    // Round-robin pick of the first eligible requester starting at the pointer.
    always_comb begin
        int idx;
        idx         = 0;
        grant_s     = '0;
        grant_any_s = 1'b0;
        grant_id_s  = '0;
        ptr_nxt_s   = ptr_r;
        sel_addr_s  = '0;
        sel_mdata_s = '0;
        if (reset && !c0.fiu_almfull) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (int'(ptr_r) + k) % N_REQ;
                if (!grant_any_s && eligible_s[idx]) begin
                    grant_any_s  = 1'b1;
                    grant_s[idx] = 1'b1;
                    grant_id_s   = ID_W'(idx);
                    ptr_nxt_s    = ID_W'((idx + 1) % N_REQ);
                    sel_addr_s   = req_addr[idx*ADDR_W +: ADDR_W];
                    sel_mdata_s  = req_mdata[idx*UW +: UW];
                end else begin
                    // an earlier requester already won this cycle
                end
            end
        end else begin
            // held in reset or FIU almost full: nobody is granted
            grant_any_s = 1'b0;
        end
    end

    // Decode the response tag; IDs beyond the requester range are flagged and dropped.
    always_comb begin
        rx_id_s  = c0.rx_mdata[MDATA_W-1 -: ID_W];
        rx_dec_s = '0;
        rx_ok_s  = 1'b0;
        rx_bad_s = 1'b0;
        if (c0.rx_valid) begin
            if ({1'b0, rx_id_s} < (ID_W+1)'(N_REQ)) begin
                rx_ok_s  = 1'b1;
                rx_dec_s = id_onehot(rx_id_s);
            end else begin
                rx_bad_s = 1'b1;
            end
        end else begin
            rx_ok_s = 1'b0;
        end
    end

    // Credit update: grant adds, response removes; a response on an empty counter is an error.
    always_comb begin
        zero_hit_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            case ({grant_s[i], rx_dec_s[i]})
                2'b10: cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
                2'b01: begin
                    if (cnt_r[i] == '0) begin
                        zero_hit_s = 1'b1;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] - CNT_W'(1);
                    end
                end
                2'b11: begin
                    if (cnt_r[i] == '0) begin
                        zero_hit_s = 1'b1;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i];
                    end
                end
                default: cnt_nxt_s[i] = cnt_r[i];
            endcase
        end
    end

    // State and registered outputs; reset clears everything and ignores responses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_r       <= '0;
            tx_valid_r  <= 1'b0;
            tx_addr_r   <= '0;
            tx_mdata_r  <= '0;
            rsp_valid_r <= '0;
            rsp_mdata_r <= '0;
            err_r       <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            ptr_r      <= ptr_nxt_s;
            tx_valid_r <= grant_any_s;
            if (grant_any_s) begin
                tx_addr_r  <= sel_addr_s;
                tx_mdata_r <= {grant_id_s, sel_mdata_s};
            end
            rsp_valid_r <= rx_dec_s;
            if (rx_ok_s) begin
                rsp_mdata_r <= c0.rx_mdata[UW-1:0];
            end
            err_r <= err_r | rx_bad_s | zero_hit_s;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Pack the credit counters onto the debug port.
    always_comb begin
        outstanding = '0;
        for (int i = 0; i < N_REQ; i++) begin
            outstanding[i*CNT_W +: CNT_W] = cnt_r[i];
        end
    end

    assign req_grant   = grant_s;
    assign c0.tx_valid = tx_valid_r;
    assign c0.tx_addr  = tx_addr_r;
    assign c0.tx_mdata = tx_mdata_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_mdata   = rsp_mdata_r;
    assign err_rsp     = err_r;

    cci_mpf_c0_rd_arb_chk #(
        .N_REQ   (N_REQ),
        .ADDR_W  (ADDR_W),
        .UW      (UW),
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_chk (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_mdata   (req_mdata),
        .req_grant   (req_grant),
        .outstanding (outstanding)
    );
endmodule

// File: tb/tb_cci_mpf_c0_rd_arb.sv
// Directed bench for cci_mpf_c0_rd_arb with N_REQ=4, MDATA_W=16, MAX_OUT=4.
module tb_cci_mpf_c0_rd_arb;
    localparam int N_REQ   = 4;
    localparam int ADDR_W  = 42;
    localparam int MDATA_W = 16;
    localparam int MAX_OUT = 4;
    localparam int UW      = 14;
    localparam int CNT_W   = 3;

    logic                    clk;
    logic                    reset;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*UW-1:0]     req_mdata;
    logic [N_REQ-1:0]        req_grant;
    logic [N_REQ-1:0]        rsp_valid;
    logic [UW-1:0]           rsp_mdata;
    logic [N_REQ*CNT_W-1:0]  outstanding;
    logic                    err_rsp;

    int tests;
    int fails;

    cci_mpf_c0_rd_arb_if #(.ADDR_W(ADDR_W), .MDATA_W(MDATA_W)) c0_if ();

    cci_mpf_c0_rd_arb #(
        .N_REQ   (N_REQ),
        .ADDR_W  (ADDR_W),
        .MDATA_W (MDATA_W),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_mdata   (req_mdata),
        .req_grant   (req_grant),
        .c0          (c0_if),
        .rsp_valid   (rsp_valid),
        .rsp_mdata   (rsp_mdata),
        .outstanding (outstanding),
        .err_rsp     (err_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ADDR_W-1:0] addr_of(input int i);
        return ADDR_W'(64'h0AB0_0000 + 64'(i) * 64'h1_0001);
    endfunction

    function automatic logic [UW-1:0] umd_of(input int i);
        return UW'(32'h100 + 32'(i) * 32'h11);
    endfunction

    function automatic logic [MDATA_W-1:0] md_of(input int i);
        return {2'(i), umd_of(i)};
    endfunction

    function automatic logic [CNT_W-1:0] cnt_of(input logic [N_REQ*CNT_W-1:0] v, input int i);
        return v[i*CNT_W +: CNT_W];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        step();
        req_valid         = '0;
        c0_if.rx_valid    = 1'b0;
        c0_if.fiu_almfull = 1'b0;
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        reset             = 1'b0;
        req_valid         = 4'hF;
        c0_if.rx_valid    = 1'b1;
        c0_if.rx_mdata    = 16'hC001;
        c0_if.fiu_almfull = 1'b0;
        repeat (3) step();
        tests++; if (c0_if.tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b want 0", c0_if.tx_valid); end
        tests++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        tests++; if (req_grant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b want 0000", req_grant); end
        tests++; if (err_rsp !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err_rsp); end
        tests++; if (outstanding !== 12'h000) begin fails++; $display("FAIL reset_outstanding: got %h want 000", outstanding); end
    endtask

    task automatic test_rr_fairness;
        logic [N_REQ-1:0] exp_g;
        c0_if.rx_valid = 1'b0;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            exp_g = 4'b0001 << (k % 4);
            tests++; if (req_grant !== exp_g) begin fails++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_grant, exp_g); end
            if (k > 0) begin
                tests++;
                if (c0_if.tx_valid !== 1'b1 || c0_if.tx_mdata !== md_of((k - 1) % 4)) begin
                    fails++; $display("FAIL rr_tx[%0d]: got v=%b md=%h want v=1 md=%h", k, c0_if.tx_valid, c0_if.tx_mdata, md_of((k - 1) % 4));
                end
            end
            step();
        end
        tests++;
        if (c0_if.tx_valid !== 1'b1 || c0_if.tx_addr !== addr_of(3) || c0_if.tx_mdata !== md_of(3)) begin
            fails++; $display("FAIL rr_tx_last: got v=%b a=%h md=%h want v=1 a=%h md=%h",
                              c0_if.tx_valid, c0_if.tx_addr, c0_if.tx_mdata, addr_of(3), md_of(3));
        end
    endtask

    task automatic test_almfull;
        tests++; if (req_grant !== 4'b0001) begin fails++; $display("FAIL af_pre0: got %b want 0001", req_grant); end
        step();
        tests++; if (req_grant !== 4'b0010) begin fails++; $display("FAIL af_pre1: got %b want 0010", req_grant); end
        step();
        c0_if.fiu_almfull = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            tests++; if (req_grant !== 4'b0000) begin fails++; $display("FAIL af_grant[%0d]: got %b want 0000", k, req_grant); end
            if (k == 0) begin
                tests++; if (c0_if.tx_valid !== 1'b1 || c0_if.tx_mdata !== md_of(1)) begin fails++; $display("FAIL af_tx_first: got v=%b md=%h want v=1 md=%h", c0_if.tx_valid, c0_if.tx_mdata, md_of(1)); end
            end else begin
                tests++; if (c0_if.tx_valid !== 1'b0) begin fails++; $display("FAIL af_tx[%0d]: got %b want 0", k, c0_if.tx_valid); end
            end
            step();
        end
        c0_if.fiu_almfull = 1'b0;
        #1;
        tests++; if (req_grant !== 4'b0100) begin fails++; $display("FAIL af_resume0: got %b want 0100", req_grant); end
        tests++; if (c0_if.tx_valid !== 1'b0) begin fails++; $display("FAIL af_tx_held: got %b want 0", c0_if.tx_valid); end
        step();
        tests++; if (req_grant !== 4'b1000) begin fails++; $display("FAIL af_resume1: got %b want 1000", req_grant); end
        tests++; if (c0_if.tx_mdata !== md_of(2)) begin fails++; $display("FAIL af_resume_tx: got %h want %h", c0_if.tx_mdata, md_of(2)); end
        step();
        tests++; if (c0_if.tx_valid !== 1'b1 || c0_if.tx_mdata !== md_of(3)) begin fails++; $display("FAIL af_resume_tx2: got v=%b md=%h want v=1 md=%h", c0_if.tx_valid, c0_if.tx_mdata, md_of(3)); end
    endtask

    task automatic test_credits;
        do_reset();
        tests++; if (outstanding !== 12'h000) begin fails++; $display("FAIL cr_cleared: got %h want 000", outstanding); end
        req_valid = 4'b0100;
        #1;
        for (int k = 0; k < 4; k++) begin
            tests++; if (req_grant !== 4'b0100) begin fails++; $display("FAIL cr_grant[%0d]: got %b want 0100", k, req_grant); end
            step();
        end
        tests++; if (req_grant !== 4'b0000) begin fails++; $display("FAIL cr_stall: got %b want 0000", req_grant); end
        tests++; if (cnt_of(outstanding, 2) !== 3'd4) begin fails++; $display("FAIL cr_count_full: got %0d want 4", cnt_of(outstanding, 2)); end
        tests++; if (c0_if.tx_valid !== 1'b1 || c0_if.tx_mdata !== md_of(2)) begin fails++; $display("FAIL cr_tx4: got v=%b md=%h want v=1 md=%h", c0_if.tx_valid, c0_if.tx_mdata, md_of(2)); end
        step();
        tests++; if (req_grant !== 4'b0000 || c0_if.tx_valid !== 1'b0) begin fails++; $display("FAIL cr_stall2: got g=%b v=%b want g=0000 v=0", req_grant, c0_if.tx_valid); end
        c0_if.rx_valid = 1'b1;
        c0_if.rx_mdata = 16'h8005;
        step();
        c0_if.rx_valid = 1'b0;
        #1;
        tests++; if (rsp_valid !== 4'b0100) begin fails++; $display("FAIL cr_rsp_valid: got %b want 0100", rsp_valid); end
        tests++; if (rsp_mdata !== 14'h0005) begin fails++; $display("FAIL cr_rsp_mdata: got %h want 0005", rsp_mdata); end
        tests++; if (cnt_of(outstanding, 2) !== 3'd3) begin fails++; $display("FAIL cr_count_dec: got %0d want 3", cnt_of(outstanding, 2)); end
        tests++; if (req_grant !== 4'b0100) begin fails++; $display("FAIL cr_grant5: got %b want 0100", req_grant); end
        step();
        tests++; if (c0_if.tx_valid !== 1'b1 || c0_if.tx_addr !== addr_of(2)) begin fails++; $display("FAIL cr_tx5: got v=%b a=%h want v=1 a=%h", c0_if.tx_valid, c0_if.tx_addr, addr_of(2)); end
        tests++; if (cnt_of(outstanding, 2) !== 3'd4 || rsp_valid !== 4'b0000) begin fails++; $display("FAIL cr_after5: got cnt=%0d rsp=%b want cnt=4 rsp=0000", cnt_of(outstanding, 2), rsp_valid); end
    endtask

    task automatic test_grant_and_rsp;
        do_reset();
        req_valid = 4'b0010;
        #1;
        tests++; if (req_grant !== 4'b0010) begin fails++; $display("FAIL gr_first: got %b want 0010", req_grant); end
        step();
        tests++; if (cnt_of(outstanding, 1) !== 3'd1) begin fails++; $display("FAIL gr_count1: got %0d want 1", cnt_of(outstanding, 1)); end
        c0_if.rx_valid = 1'b1;
        c0_if.rx_mdata = 16'h40AB;
        #1;
        tests++; if (req_grant !== 4'b0010) begin fails++; $display("FAIL gr_second: got %b want 0010", req_grant); end
        step();
        c0_if.rx_valid = 1'b0;
        #1;
        tests++; if (cnt_of(outstanding, 1) !== 3'd1) begin fails++; $display("FAIL gr_count_same: got %0d want 1", cnt_of(outstanding, 1)); end
        tests++; if (rsp_valid !== 4'b0010 || rsp_mdata !== 14'h00AB) begin fails++; $display("FAIL gr_rsp: got v=%b md=%h want v=0010 md=00ab", rsp_valid, rsp_mdata); end
        tests++; if (err_rsp !== 1'b0) begin fails++; $display("FAIL gr_err: got %b want 0", err_rsp); end
    endtask

    task automatic test_err_rsp;
        do_reset();
        c0_if.rx_valid = 1'b1;
        c0_if.rx_mdata = 16'hC00F;
        step();
        c0_if.rx_valid = 1'b0;
        #1;
        tests++; if (err_rsp !== 1'b1) begin fails++; $display("FAIL er_set: got %b want 1", err_rsp); end
        tests++; if (rsp_valid !== 4'b1000 || rsp_mdata !== 14'h000F) begin fails++; $display("FAIL er_fwd: got v=%b md=%h want v=1000 md=000f", rsp_valid, rsp_mdata); end
        tests++; if (cnt_of(outstanding, 3) !== 3'd0) begin fails++; $display("FAIL er_count: got %0d want 0", cnt_of(outstanding, 3)); end
        repeat (3) step();
        tests++; if (err_rsp !== 1'b1 || rsp_valid !== 4'b0000) begin fails++; $display("FAIL er_sticky: got err=%b rsp=%b want err=1 rsp=0000", err_rsp, rsp_valid); end
        reset = 1'b0;
        step();
        tests++; if (err_rsp !== 1'b0) begin fails++; $display("FAIL er_cleared: got %b want 0", err_rsp); end
        reset = 1'b1;
    endtask

    initial begin
        tests             = 0;
        fails             = 0;
        reset             = 1'b0;
        req_valid         = '0;
        c0_if.fiu_almfull = 1'b0;
        c0_if.rx_valid    = 1'b0;
        c0_if.rx_mdata    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = addr_of(i);
            req_mdata[i*UW +: UW]        = umd_of(i);
        end
        test_reset();
        test_rr_fairness();
        test_almfull();
        test_credits();
        test_grant_and_rsp();
        test_err_rsp();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
